// File: rtl/mem_line_bridge_pkg.sv
// -----------------------------------------------------------------------------
// mem_line_bridge_pkg
// Shared types and constants for the single-line bridge between the RV32I
// multicycle CPU word port and the 64-bit burst physical memory.
//   rv32i_word      : 32-bit CPU word / address
//   line_t          : one 256-bit line (4 beats of 64 bits, little-endian)
//   tag_t           : address bits [31:5]
//   beat_t          : one 64-bit burst beat
//   bridge_state_t  : bridge FSM states
// -----------------------------------------------------------------------------
package mem_line_bridge_pkg;

  typedef logic [31:0] rv32i_word;

  localparam int LINE_BEATS  = 4;
  localparam int OFFSET_BITS = 5;

  typedef logic [255:0]              line_t;
  typedef logic [31-OFFSET_BITS:0]   tag_t;
  typedef logic [63:0]               beat_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    MERGE = 3'd2,
    WBACK = 3'd3,
    RESP  = 3'd4
  } bridge_state_t;

  // Tag portion of a CPU byte address.
  function automatic tag_t addr_tag(input rv32i_word addr);
    return addr[31:OFFSET_BITS];
  endfunction

endpackage

// File: rtl/mem_line_bridge_byte_merge.sv
// -----------------------------------------------------------------------------
// byte_merge
// Combinational byte-lane merge of a CPU store into an existing word.
//   old_word    in  32  current word in the line
//   new_word    in  32  CPU write data
//   byte_enable in  4   lane i selects new_word byte i
//   merged_word out 32  result
// -----------------------------------------------------------------------------
module byte_merge
  import mem_line_bridge_pkg::*;
(
  input  rv32i_word   old_word,
  input  rv32i_word   new_word,
  input  logic [3:0]  byte_enable,
  output rv32i_word   merged_word
);

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_enable[i]) begin
        merged_word[8*i +: 8] = new_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_line_bridge.sv
// -----------------------------------------------------------------------------
// mem_line_bridge
// One-line buffer between the CPU word port and 64-bit burst physical memory.
// Read hits are answered from the line; misses fill the line with a 4-beat
// burst. Writes allocate the line, merge the enabled bytes and write the
// whole line back with a 4-beat burst (write-through).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mem_read / mem_write     CPU request, held until mem_resp
//   mem_byte_enable[3:0]     byte lanes of mem_wdata to write
//   mem_address[31:0]        CPU byte address (bits [1:0] ignored)
//   mem_wdata[31:0]          CPU write data
//   mem_rdata[31:0]          addressed word, valid while mem_resp=1
//   mem_resp                 one-cycle completion pulse
//   pmem_read / pmem_write   burst request, held until the 4th beat
//   pmem_address[31:0]       line-aligned burst address
//   pmem_wdata[63:0]         write beat data
//   pmem_rdata[63:0]         read beat data, valid with pmem_resp
//   pmem_resp                one pulse per accepted beat
// -----------------------------------------------------------------------------
module mem_line_bridge
  import mem_line_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [63:0] pmem_wdata,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);

  // Control state (asynchronously reset)
  bridge_state_t state_q;
  bridge_state_t state_d;
  logic          valid_q;
  logic [1:0]    cnt_q;

  // Line storage and captured request (no reset; guarded by valid_q/state_q)
  tag_t          tag_q;
  line_t         line_q;
  logic [31:2]   req_addr_q;
  rv32i_word     req_wdata_q;
  logic [3:0]    req_be_q;
  logic          req_write_q;

  logic          req_any;
  logic          hit;
  logic          last_beat;
  logic [2:0]    word_idx;
  rv32i_word     old_word;
  rv32i_word     merged_word;
  beat_t         cur_beat;
  logic          addr_unused;

  // Byte offset within a word never affects the line access.
  assign addr_unused = ^mem_address[1:0];

  assign req_any   = mem_read | mem_write;
  assign hit       = valid_q && (tag_q == addr_tag(mem_address));
  assign last_beat = pmem_resp && (cnt_q == 2'(LINE_BEATS - 1));
  assign word_idx  = req_addr_q[4:2];
  assign old_word  = line_q[{word_idx, 5'b0} +: 32];
  assign cur_beat  = line_q[{cnt_q, 6'b0} +: 64];

  byte_merge u_byte_merge (
    .old_word    (old_word),
    .new_word    (req_wdata_q),
    .byte_enable (req_be_q),
    .merged_word (merged_word)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_read && hit) begin
          state_d = RESP;
        end else if (mem_write && hit) begin
          state_d = MERGE;
        end else if (req_any) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (last_beat) begin
          state_d = req_write_q ? MERGE : RESP;
        end
      end
      MERGE: state_d = WBACK;
      WBACK: begin
        if (last_beat) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers. valid_q is dropped when a fill starts so that a burst
  // cut short by reset can never leave a half-written line marked valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_any && !hit) begin
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            cnt_q <= cnt_q + 2'd1;
            if (last_beat) begin
              valid_q <= 1'b1;
            end
          end
        end
        MERGE: cnt_q <= 2'd0;
        WBACK: begin
          if (pmem_resp) begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: request capture, fill beats, byte merge.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_any) begin
      req_addr_q  <= mem_address[31:2];
      req_wdata_q <= mem_wdata;
      req_be_q    <= mem_byte_enable;
      req_write_q <= mem_write;
    end
    if (state_q == FILL && pmem_resp) begin
      line_q[{cnt_q, 6'b0} +: 64] <= pmem_rdata;
      if (last_beat) begin
        tag_q <= req_addr_q[31:OFFSET_BITS];
      end
    end
    if (state_q == MERGE) begin
      line_q[{word_idx, 5'b0} +: 32] <= merged_word;
    end
  end

  // Moore outputs; all zero outside the states that drive them, so reset
  // forces every output low immediately.
  always_comb begin
    mem_resp     = (state_q == RESP);
    mem_rdata    = (state_q == RESP) ? old_word : 32'h0;
    pmem_read    = (state_q == FILL);
    pmem_write   = (state_q == WBACK);
    pmem_address = (state_q == FILL || state_q == WBACK)
                 ? {req_addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : 32'h0;
    pmem_wdata   = (state_q == WBACK) ? cur_beat : 64'h0;
  end

endmodule

// File: tb/tb_mem_line_bridge.sv
// -----------------------------------------------------------------------------
// tb_mem_line_bridge
// Directed, table-driven bench for mem_line_bridge with a behavioural burst
// memory (configurable idle gap before every beat) and a reset-abort sequence.
// -----------------------------------------------------------------------------
module tb_mem_line_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  always #5 clk = ~clk;

  mem_line_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          gap = 0;
  int          rd_beats = 0;
  int          wr_beats = 0;
  logic [31:0] last_paddr = 32'h0;
  logic [63:0] pmem_mem [0:1023];

  // Burst memory model: waits 'gap' cycles, then returns/accepts one beat.
  // Index is {address[12:5], beat}.
  initial begin : pmem_model
    logic [1:0] beat;
    int         wait_cnt;
    beat       = 2'd0;
    wait_cnt   = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = 64'h0;
    for (int i = 0; i < 1024; i++) pmem_mem[i] = 64'h0;
    pmem_mem[8]   = 64'h1111_1111_1111_1111;
    pmem_mem[9]   = 64'h2222_2222_2222_2222;
    pmem_mem[10]  = 64'h3333_3333_3333_3333;
    pmem_mem[11]  = 64'h4444_4444_4444_4444;
    pmem_mem[512] = 64'hA0A0_A0A0_B0B0_B0B0;
    pmem_mem[513] = 64'hC1C1_C1C1_D1D1_D1D1;
    pmem_mem[514] = 64'hE2E2_E2E2_F2F2_F2F2;
    pmem_mem[515] = 64'h0303_0303_1313_1313;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst || !(pmem_read || pmem_write)) begin
        beat     = 2'd0;
        wait_cnt = 0;
      end else if (wait_cnt < gap) begin
        wait_cnt++;
      end else begin
        wait_cnt   = 0;
        last_paddr = pmem_address;
        if (pmem_read) begin
          pmem_rdata = pmem_mem[{pmem_address[12:5], beat}];
          rd_beats++;
        end else begin
          pmem_mem[{pmem_address[12:5], beat}] = pmem_wdata;
          wr_beats++;
        end
        pmem_resp = 1'b1;
        beat      = beat + 2'd1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One CPU transaction; lat counts falling edges from request to mem_resp.
  task automatic cpu_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int lat);
    bit done;
    done = 1'b0;
    lat  = 0;
    rd   = 32'h0;
    @(negedge clk);
    mem_address     = addr;
    mem_wdata       = wd;
    mem_byte_enable = be;
    mem_read        = !wr;
    mem_write       = wr;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (mem_resp) begin
        done = 1'b1;
        rd   = mem_rdata;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL resp_timeout: no mem_resp for addr 0x%0h within %0d cycles", addr, lat);
      lat = -1;
    end else begin
      @(negedge clk);
      check("resp_single_pulse", 64'(mem_resp), 64'd0);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gap;
    logic [31:0] exp_rdata;
    int          exp_lat;   // -1: not checked
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_paddr;
    bit          chk_mem;
    int          mem_idx;
    logic [63:0] exp_mem;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be,
                              int g, logic [31:0] erd, int elat, int erdb, int ewrb,
                              logic [31:0] epa, bit cm, int idx, logic [63:0] emem);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.gap = g;
    v.exp_rdata = erd; v.exp_lat = elat; v.exp_rd = erdb; v.exp_wr = ewrb;
    v.exp_paddr = epa; v.chk_mem = cm; v.mem_idx = idx; v.exp_mem = emem;
    return v;
  endfunction

  initial begin : main
    vec_t        vecs [9];
    logic [31:0] rd;
    int          lat;
    int          rd0;
    int          wr0;
    int          waited;

    //            wr    addr          wdata         be       gap  rdata         lat rd wr paddr         mem idx  expected beat
    vecs[0] = mk(1'b0, 32'h0000_0040, 32'h0,        4'b0000, 0,   32'h1111_1111, -1, 4, 0, 32'h0000_0040, 0,  0,   64'h0);
    vecs[1] = mk(1'b0, 32'h0000_005C, 32'h0,        4'b0000, 0,   32'h4444_4444,  1, 0, 0, 32'h0,         0,  0,   64'h0);
    vecs[2] = mk(1'b1, 32'h0000_0048, 32'hAABBCCDD, 4'b0101, 0,   32'h22BB_22DD,  6, 0, 4, 32'h0000_0040, 1,  9,   64'h2222_2222_22BB_22DD);
    vecs[3] = mk(1'b0, 32'h0000_0048, 32'h0,        4'b0000, 0,   32'h22BB_22DD,  1, 0, 0, 32'h0,         0,  0,   64'h0);
    vecs[4] = mk(1'b1, 32'h0000_004C, 32'hFFFFFFFF, 4'b0000, 0,   32'h2222_2222,  6, 0, 4, 32'h0000_0040, 1,  9,   64'h2222_2222_22BB_22DD);
    vecs[5] = mk(1'b1, 32'h0000_1000, 32'h12345678, 4'b1111, 1,   32'h1234_5678, 18, 4, 4, 32'h0000_1000, 1,  512, 64'hA0A0_A0A0_1234_5678);
    vecs[6] = mk(1'b0, 32'h0000_0048, 32'h0,        4'b0000, 3,   32'h22BB_22DD, 17, 4, 0, 32'h0000_0040, 0,  0,   64'h0);
    vecs[7] = mk(1'b0, 32'h0000_005C, 32'h0,        4'b0000, 0,   32'h4444_4444,  1, 0, 0, 32'h0,         0,  0,   64'h0);
    vecs[8] = mk(1'b0, 32'h0000_1004, 32'h0,        4'b0000, 0,   32'hA0A0_A0A0,  5, 4, 0, 32'h0000_1000, 0,  0,   64'h0);

    rst             = 1'b1;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'h0;
    mem_address     = 32'h0;
    mem_wdata       = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_mem_resp",     64'(mem_resp),     64'd0);
    check("rst_mem_rdata",    64'(mem_rdata),    64'd0);
    check("rst_pmem_read",    64'(pmem_read),    64'd0);
    check("rst_pmem_write",   64'(pmem_write),   64'd0);
    check("rst_pmem_address", 64'(pmem_address), 64'd0);
    check("rst_pmem_wdata",   pmem_wdata,        64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      gap = vecs[i].gap;
      rd0 = rd_beats;
      wr0 = wr_beats;
      cpu_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, lat);
      check($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      if (vecs[i].exp_lat >= 0)
        check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_read_beats", i),  64'(rd_beats - rd0), 64'(vecs[i].exp_rd));
      check($sformatf("v%0d_write_beats", i), 64'(wr_beats - wr0), 64'(vecs[i].exp_wr));
      if (vecs[i].exp_rd + vecs[i].exp_wr > 0)
        check($sformatf("v%0d_pmem_address", i), 64'(last_paddr), 64'(vecs[i].exp_paddr));
      if (vecs[i].chk_mem)
        check($sformatf("v%0d_pmem_beat", i), pmem_mem[vecs[i].mem_idx], vecs[i].exp_mem);
    end

    // Reset in the middle of a fill of line 0x40 (gap 3 keeps beat 3 far away).
    gap = 3;
    rd0 = rd_beats;
    @(negedge clk);
    mem_address = 32'h0000_0040;
    mem_read    = 1'b1;
    waited      = 0;
    while ((rd_beats - rd0) < 2 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #2;
    check("abort_beats_before_rst", 64'(rd_beats - rd0), 64'd2);
    check("abort_pmem_read_high",   64'(pmem_read),      64'd1);
    rst = 1'b1;
    #1;
    check("abort_pmem_read_drop",   64'(pmem_read),    64'd0);
    check("abort_pmem_addr_zero",   64'(pmem_address), 64'd0);
    check("abort_mem_resp_low",     64'(mem_resp),     64'd0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Same read again must miss and refetch the whole line.
    gap = 0;
    rd0 = rd_beats;
    wr0 = wr_beats;
    cpu_op(1'b0, 32'h0000_0040, 32'h0, 4'b0000, rd, lat);
    check("refetch_rdata",       64'(rd),                64'h1111_1111);
    check("refetch_read_beats",  64'(rd_beats - rd0),    64'd4);
    check("refetch_write_beats", 64'(wr_beats - wr0),    64'd0);
    check("refetch_latency",     64'(lat),               64'd5);

    // Beat 1 of the refetched line still holds the written-back merge.
    rd0 = rd_beats;
    cpu_op(1'b0, 32'h0000_0048, 32'h0, 4'b0000, rd, lat);
    check("after_abort_hit_rdata", 64'(rd),             64'h22BB_22DD);
    check("after_abort_hit_beats", 64'(rd_beats - rd0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
